mem_requester: RTL and testbench

Initiator side of the dataflow memory port protocol. Accepts memory commands (address, data and write-enable tokens) from upstream dataflow nodes and buffers them in order. Issues one request at a time to a single memory port of the dual-port memory block. Forwards read results downstream and absorbs write acknowledgements, with a watchdog for lost responses.

---
 rtl/dataflow_pkg.sv | 22 ++
 rtl/cmd_fifo.sv | 53 +++++
 rtl/mem_requester.sv | 136 +++++++++++++
 tb/tb_mem_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared widths, requester state and command bundle
// for the dataflow memory port.
`timescale 1ns/1ps
package dataflow_pkg;

  localparam int ADDR_LENGTH      = 8;
  localparam int MEM_ENTRY_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DELIVER
  } req_state_t;

  typedef struct packed {
    logic [ADDR_LENGTH-1:0]      addr;
    logic [MEM_ENTRY_LENGTH-1:0] data;
    logic                        we;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// In-order command buffer, power-of-two depth,
// count-based full/empty.
`timescale 1ns/1ps
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = push & ~full;
  assign do_rd = pop & ~empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_requester.sv
// Memory port initiator: buffers commands, issues one
// request at a time, forwards reads, watches for lost responses.
`timescale 1ns/1ps
module mem_requester
  import dataflow_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 31
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_LENGTH:0]        cmd_addr,
  input  logic [MEM_ENTRY_LENGTH:0]   cmd_data,
  input  logic [1:0]                  cmd_wren,
  output logic                        cmd_stop,
  output logic [ADDR_LENGTH:0]        mem_addr,
  output logic [MEM_ENTRY_LENGTH:0]   mem_data,
  output logic [1:0]                  mem_wren,
  input  logic                        mem_addr_stop,
  input  logic                        mem_data_stop,
  input  logic                        mem_wren_stop,
  input  logic [MEM_ENTRY_LENGTH:0]   mem_q,
  output logic                        mem_q_stop,
  output logic [MEM_ENTRY_LENGTH:0]   rsp_data,
  input  logic                        rsp_stop,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  req_state_t                  state;
  cmd_t                        cmd_in;
  cmd_t                        head;
  cmd_t                        req;
  logic                        req_v;
  logic                        rsp_v;
  logic [MEM_ENTRY_LENGTH-1:0] rsp;
  logic [WDW-1:0]              wd;
  logic                        terr;
  logic                        full;
  logic                        empty;
  logic                        push;
  logic                        pop;
  logic                        mem_stall;

  assign push = cmd_addr[ADDR_LENGTH] & cmd_data[MEM_ENTRY_LENGTH]
              & cmd_wren[1] & ~full;
  assign pop  = (state == IDLE) & ~empty;

  assign cmd_in = '{addr: cmd_addr[ADDR_LENGTH-1:0],
                    data: cmd_data[MEM_ENTRY_LENGTH-1:0],
                    we:   cmd_wren[0]};

  assign mem_stall = mem_addr_stop | mem_data_stop | mem_wren_stop;

  cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req   <= '0;
      req_v <= 1'b0;
      rsp   <= '0;
      rsp_v <= 1'b0;
      wd    <= '0;
      terr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            req   <= head;
            req_v <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!mem_stall) begin
            req_v <= 1'b0;
            wd    <= '0;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response on the final watchdog edge still wins.
          if (mem_q[MEM_ENTRY_LENGTH]) begin
            if (req.we) begin
              state <= IDLE;
            end else begin
              rsp   <= mem_q[MEM_ENTRY_LENGTH-1:0];
              rsp_v <= 1'b1;
              state <= DELIVER;
            end
          end else begin
            if (wd != WD_MAX) wd <= wd + 1'b1;
            if (wd == WD_LAST) begin
              terr  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        DELIVER: begin
          if (!rsp_stop) begin
            rsp_v <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_stop    = full;
  assign mem_addr    = {req_v, req.addr};
  assign mem_data    = {req_v, req.data};
  assign mem_wren    = {req_v, req.we};
  assign mem_q_stop  = (state != WAIT_RSP);
  assign rsp_data    = {rsp_v, rsp};
  assign busy        = ~empty | (state != IDLE);
  assign timeout_err = terr;

endmodule

// File: tb/tb_mem_requester.sv
// Randomized bench for mem_requester with a transaction-level
// reference model and a few hand-computed anchors.
`timescale 1ns/1ps
module tb_mem_requester;
  import dataflow_pkg::*;

  localparam int AL = ADDR_LENGTH;
  localparam int ML = MEM_ENTRY_LENGTH;
  localparam int D  = 4;
  localparam int TO = 31;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AL:0]   cmd_addr = '0;
  logic [ML:0]   cmd_data = '0;
  logic [1:0]    cmd_wren = '0;
  logic          cmd_stop;
  logic [AL:0]   mem_addr;
  logic [ML:0]   mem_data;
  logic [1:0]    mem_wren;
  logic          mem_addr_stop = 1'b0;
  logic          mem_data_stop = 1'b0;
  logic          mem_wren_stop = 1'b0;
  logic [ML:0]   mem_q = '0;
  logic          mem_q_stop;
  logic [ML:0]   rsp_data;
  logic          rsp_stop = 1'b0;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_requester #(
    .CMD_DEPTH (D),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_wren      (cmd_wren),
    .cmd_stop      (cmd_stop),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .mem_addr_stop (mem_addr_stop),
    .mem_data_stop (mem_data_stop),
    .mem_wren_stop (mem_wren_stop),
    .mem_q         (mem_q),
    .mem_q_stop    (mem_q_stop),
    .rsp_data      (rsp_data),
    .rsp_stop      (rsp_stop),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queued commands, one outstanding request.
  // ph: 0 waiting for work, 1 offering request, 2 awaiting reply,
  // 3 holding read result.
  cmd_t          mq[$];
  int            ph;
  cmd_t          cur;
  int            wd;
  logic [ML-1:0] rsp;
  bit            rsp_v;
  bit            terr;

  // Stimulus state and knobs
  cmd_t          src[$];
  cmd_t          tmp;
  bit            hold, auto_cmd, never_rsp, rsp_hold;
  int            cmd_pct, stop_pct, rstop_pct, part_pct;
  int            dly_min, dly_max, drop_pct, spur_pct;
  bit            rpend, spur;
  int            rdly;
  logic [ML-1:0] rdat;
  logic [ML-1:0] mem_m [2**AL];
  logic [2:0]    pv;
  bit            acc_x, mreq_x, rq_x, rsp_seen;
  cmd_t          mreq_c;
  logic [AL-1:0] iss[$];
  int            n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task model_reset;
    mq.delete();
    ph = 0; cur = '0; wd = 0;
    rsp = '0; rsp_v = 0; terr = 0;
  endtask

  task model_step;
    bit accept;
    accept = cmd_addr[AL] && cmd_data[ML] && cmd_wren[1] &&
             (mq.size() < D);
    case (ph)
      0: if (mq.size() > 0) begin cur = mq.pop_front(); ph = 1; end
      1: if (!mem_addr_stop && !mem_data_stop && !mem_wren_stop) begin
           ph = 2; wd = 0;
         end
      2: if (mem_q[ML]) begin
           if (cur.we) ph = 0;
           else begin rsp = mem_q[ML-1:0]; rsp_v = 1; ph = 3; end
         end else begin
           wd++;
           if (wd >= TO) begin terr = 1; ph = 0; end
         end
      default: if (!rsp_stop) begin rsp_v = 0; ph = 0; end
    endcase
    if (accept)
      mq.push_back('{addr: cmd_addr[AL-1:0], data: cmd_data[ML-1:0],
                     we: cmd_wren[0]});
  endtask

  task compare_all;
    chk("cmd_stop", cmd_stop, mq.size() == D);
    chk("mem_addr", mem_addr, {ph == 1, cur.addr});
    chk("mem_data", mem_data, {ph == 1, cur.data});
    chk("mem_wren", mem_wren, {ph == 1, cur.we});
    chk("mem_q_stop", mem_q_stop, ph != 2);
    chk("rsp_data", rsp_data, {rsp_v, rsp});
    chk("busy", busy, (mq.size() > 0) || (ph != 0));
    chk("timeout_err", timeout_err, terr);
  endtask

  task clear_stim;
    src.delete();
    hold = 0;
    cmd_addr[AL] = 1'b0; cmd_data[ML] = 1'b0; cmd_wren[1] = 1'b0;
    mem_q = '0; rpend = 0; spur = 0;
  endtask

  task drive;
    // command producer
    if (hold && acc_x) begin hold = 0; void'(src.pop_front()); end
    if (auto_cmd && src.size() < 3 && $urandom_range(0, 99) < 60) begin
      tmp.addr = AL'($urandom_range(0, 7));
      tmp.data = ML'($urandom);
      tmp.we   = 1'($urandom_range(0, 1));
      src.push_back(tmp);
    end
    if (!hold && src.size() > 0 && $urandom_range(0, 99) < cmd_pct) begin
      cmd_addr = {1'b1, src[0].addr};
      cmd_data = {1'b1, src[0].data};
      cmd_wren = {1'b1, src[0].we};
      hold = 1;
    end else if (!hold) begin
      if ($urandom_range(0, 99) < part_pct) begin
        pv = 3'($urandom_range(0, 6));
        cmd_addr = {pv[0], AL'($urandom)};
        cmd_data = {pv[1], ML'($urandom)};
        cmd_wren = {pv[2], 1'($urandom)};
      end else begin
        cmd_addr[AL] = 1'b0; cmd_data[ML] = 1'b0; cmd_wren[1] = 1'b0;
      end
    end
    // memory port
    mem_addr_stop = $urandom_range(0, 99) < stop_pct;
    mem_data_stop = $urandom_range(0, 99) < stop_pct;
    mem_wren_stop = $urandom_range(0, 99) < stop_pct;
    if (spur) begin mem_q[ML] = 1'b0; spur = 0; end
    if (mem_q[ML] && rq_x) begin mem_q[ML] = 1'b0; rpend = 0; end
    if (mreq_x) begin
      if (mreq_c.we) begin
        mem_m[mreq_c.addr] = mreq_c.data;
        rdat = ML'($urandom);
      end else rdat = mem_m[mreq_c.addr];
      rpend = !(never_rsp || $urandom_range(0, 99) < drop_pct);
      rdly  = $urandom_range(dly_min, dly_max);
    end
    if (rpend && !mem_q[ML]) begin
      if (rdly == 0) mem_q = {1'b1, rdat};
      else rdly--;
    end else if (!rpend && !mem_q[ML] && ph != 2 &&
                 $urandom_range(0, 99) < spur_pct) begin
      mem_q = {1'b1, ML'($urandom)};
      spur = 1;
    end
    // downstream consumer
    rsp_stop = rsp_hold ? 1'b1 : ($urandom_range(0, 99) < rstop_pct);
  endtask

  task tick;
    @(negedge clk);
    compare_all();
    acc_x  = cmd_addr[AL] && cmd_data[ML] && cmd_wren[1] && !cmd_stop;
    mreq_x = mem_wren[1] && !mem_addr_stop && !mem_data_stop &&
             !mem_wren_stop;
    rq_x   = mem_q[ML] && !mem_q_stop;
    if (mreq_x) begin
      iss.push_back(mem_addr[AL-1:0]);
      mreq_c = '{addr: mem_addr[AL-1:0], data: mem_data[ML-1:0],
                 we: mem_wren[0]};
    end
    if (rsp_data[ML]) rsp_seen = 1;
    if (rst_n) model_step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task do_reset;
    rst_n = 1'b0;
    clear_stim();
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2**AL; i++) mem_m[i] = '0;
    model_reset();
    clear_stim();
    auto_cmd = 0; cmd_pct = 100; stop_pct = 0; rstop_pct = 0;
    part_pct = 0; dly_min = 2; dly_max = 2; drop_pct = 0;
    spur_pct = 0; never_rsp = 0; rsp_hold = 0;
    acc_x = 0; mreq_x = 0; rq_x = 0; rsp_seen = 0;

    // reset values
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_q_stop", mem_q_stop, 1);
    chk("rst_cmd_stop", cmd_stop, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_rsp", rsp_data, 0);
    tick();
    rst_n = 1'b1;

    // write 0x05 <- 0xAB
    rsp_seen = 0;
    src.push_back('{addr: 8'h05, data: 8'hAB, we: 1'b1});
    n = 0;
    while (n < 20 && !mem_wren[1]) begin tick(); n++; end
    chk("wr_latency", n, 3);
    chk("wr_mem_addr", mem_addr, 9'h105);
    chk("wr_mem_data", mem_data, 9'h1AB);
    chk("wr_mem_wren", mem_wren, 2'b11);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("wr_idle", busy, 0);
    chk("wr_no_rsp", rsp_seen, 0);

    // read 0x05 with downstream stalled, write 0x06 queued behind
    rsp_hold = 1;
    src.push_back('{addr: 8'h05, data: 8'h00, we: 1'b0});
    src.push_back('{addr: 8'h06, data: 8'h3C, we: 1'b1});
    for (int i = 0; i < 30 && !rsp_data[ML]; i++) tick();
    chk("rd_rsp", rsp_data, 9'h1AB);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rd_hold", rsp_data, 9'h1AB);
    end
    chk("rd_hold_no_issue", mem_wren[1], 0);
    chk("rd_hold_q_stop", mem_q_stop, 1);
    rsp_hold = 0; rsp_stop = 1'b0;
    tick();
    chk("rd_release", rsp_data[ML], 0);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("rd_idle", busy, 0);

    // reply on the last watchdog edge is accepted
    dly_min = TO - 1; dly_max = TO - 1;
    src.push_back('{addr: 8'h06, data: 8'h00, we: 1'b0});
    for (int i = 0; i < 80 && !rsp_data[ML]; i++) tick();
    chk("bnd_rsp", rsp_data, 9'h13C);
    chk("bnd_no_to", timeout_err, 0);
    for (int i = 0; i < 20 && busy; i++) tick();
    dly_min = 2; dly_max = 2;

    // five commands behind a stalled memory
    stop_pct = 100;
    iss.delete();
    for (int k = 1; k <= 5; k++)
      src.push_back('{addr: AL'(k), data: ML'(8'h10 + k), we: 1'b1});
    for (int i = 0; i < 30 && !cmd_stop; i++) tick();
    chk("full_stop", cmd_stop, 1);
    chk("full_all_acc", src.size(), 0);
    tick();
    chk("full_stop_hold", cmd_stop, 1);
    stop_pct = 0;
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("order_n", iss.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("order", (k < iss.size()) ? 32'(iss[k]) : 32'hFFFF, k + 1);

    // lost response: watchdog fires, queue continues
    never_rsp = 1;
    src.push_back('{addr: 8'h07, data: 8'h00, we: 1'b0});
    src.push_back('{addr: 8'h03, data: 8'h55, we: 1'b1});
    for (int i = 0; i < 20 && mem_q_stop; i++) tick();
    n = 0;
    while (n < TO + 5 && !timeout_err) begin tick(); n++; end
    chk("to_cycles", n, TO);
    chk("to_flag", timeout_err, 1);
    never_rsp = 0;
    iss.delete();
    for (int i = 0; i < 20 && iss.size() == 0; i++) tick();
    chk("to_next", (iss.size() > 0) ? 32'(iss[0]) : 32'hFFFF, 3);
    for (int i = 0; i < 40 && busy; i++) tick();

    // reset while waiting, two commands queued
    never_rsp = 1;
    src.push_back('{addr: 8'h01, data: 8'h00, we: 1'b0});
    src.push_back('{addr: 8'h02, data: 8'h22, we: 1'b1});
    src.push_back('{addr: 8'h03, data: 8'h33, we: 1'b1});
    for (int i = 0; i < 20 && mem_q_stop; i++) tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    clear_stim();
    model_reset();
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_stop", cmd_stop, 0);
    chk("mid_rst_q_stop", mem_q_stop, 1);
    chk("mid_rst_wren", mem_wren, 0);
    chk("mid_rst_rsp", rsp_data, 0);
    chk("mid_rst_terr", timeout_err, 0);
    tick();
    rst_n = 1'b1;
    never_rsp = 0;
    mem_q = {1'b1, 8'h77};
    for (int i = 0; i < 3; i++) tick();
    chk("stale_busy", busy, 0);
    chk("stale_rsp", rsp_data[ML], 0);
    mem_q = '0;
    tick();

    // randomized traffic
    auto_cmd = 1; cmd_pct = 70; stop_pct = 30; rstop_pct = 30;
    part_pct = 15; dly_min = 0; dly_max = 8; drop_pct = 3;
    spur_pct = 5;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      tick();
    end
    auto_cmd = 0; part_pct = 0; drop_pct = 0;
    for (int i = 0; i < 500 && (busy || hold || src.size() > 0); i++)
      tick();
    chk("drain", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
